root5_pipelined: RTL and testbench
==================================

Name: root5_pipelined

Overview:
- Pipelined integer fifth-root extractor. It is the inverse of the team's pipelined x^5 power block.
- Takes a 5*DATA_WIDTH-bit unsigned value x and produces r = floor(x^(1/5)), the remainder x - r^5, and an exact flag.
- Uses a fully pipelined bit-serial trial method with one pipeline stage per root bit, MSB first.
- Accepts one operand per clock, with no backpressure. Used in datapath examples alongside power and pipeline blocks.

Parameters:
- DATA_WIDTH, 8, width of the root. The operand is 5*DATA_WIDTH bits.
- LATENCY, DATA_WIDTH+2, localparam (not overridable): input register, plus DATA_WIDTH trial stages, plus output register.

Ports:
- clk_i  input  1  clock; all registers update on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  operand valid; sampled every rising edge.
- root_data_i  input  5*DATA_WIDTH  unsigned operand x.
- valid_o  output  1  result valid, one cycle per accepted operand.
- root_data_o  output  DATA_WIDTH  floor fifth root r.
- rem_data_o  output  5*DATA_WIDTH  remainder x - r^5.
- exact_o  output  1  1 when the remainder is 0.

Behaviour:
- Reset (asynchronous, while rst_i=1):
  - every stage valid bit, valid_o, root_data_o, rem_data_o and exact_o are 0;
  - all internal data registers are 0.
- Latency: if valid_i=1 in cycle t, the matching result and valid_o=1 appear in cycle t+LATENCY (t+10 for DATA_WIDTH=8).
- Throughput: 1 result per cycle. Bubbles on valid_i propagate unchanged, and ordering is preserved.
- Stage 0 (input register) captures x and valid_i.
- Trial stage k (k=1..DATA_WIDTH) decides root bit b = DATA_WIDTH-k:
  - candidate c = r_prev | (1<<b);
  - p = c^5, computed at full 5*DATA_WIDTH width; it cannot overflow because c < 2^DATA_WIDTH;
  - if p <= x then r = c, else r = r_prev;
  - the stage registers x, r and valid;
  - r entering stage 1 is 0.
- Output stage:
  - computes rem = x - r^5; this is never negative by construction;
  - exact = (rem == 0);
  - registers root, rem, exact and valid_o.
- Data registers in every stage load only when the incoming valid=1, and hold otherwise. Outputs therefore keep the last result while valid_o=0.
- Boundary values:
  - x=0 gives r=0, rem=0, exact=1.
  - x = 2^(5*DATA_WIDTH)-1 gives r = 2^DATA_WIDTH-1 with a nonzero remainder.
- Reset mid-operation:
  - all in-flight operands are dropped and no valid_o is produced for them;
  - the first operand after reset deassertion appears LATENCY cycles after it is sampled.
- No state machine: a pure valid-tagged pipeline.

Decomposition:
- Package root5_pkg: the LATENCY function of DATA_WIDTH, and a stage struct typedef {valid, x[5*DW], r[DW]}, parameterised through a localparam width in the package.
- Sub-module root5_trial_stage (parameters DATA_WIDTH and BIT):
  - combinational c^5 as a chain of 4 multiplies at growing widths;
  - compare and select;
  - registered output with async reset.
- The top instantiates DATA_WIDTH of these stages through a generate loop, plus the input and output registers.

Test Plan (DATA_WIDTH=8):
- Single operands with gaps:
  - x=0 -> r=0, rem=0, exact=1;
  - x=31 -> r=1, rem=30, exact=0;
  - x=243 -> r=3, rem=0, exact=1;
  - x=244 -> r=3, rem=1, exact=0.
  - Each result appears exactly 10 cycles after its valid_i cycle.
- Extremes:
  - x=1078203909375 (255^5) -> r=255, rem=0, exact=1;
  - x=1099511627775 (2^40-1) -> r=255, rem=21307718400, exact=0.
- Back-to-back stream: 32, 1024, 3125, 7776 on consecutive cycles -> roots 2, 4, 5, 6 on 4 consecutive cycles, all exact. Then insert the bubble pattern 1,0,1 -> valid_o shows the same pattern, and data holds during the bubble.
- Reset mid-stream: assert rst_i for 1 cycle while 5 operands are in flight.
  - All outputs are 0 immediately (asynchronous).
  - No valid_o for the dropped operands.
  - A new x=243 gives r=3 after 10 cycles.
- Randomized round trip: random r in 0..255 feeds an x^5 model, then random x+delta with delta < (r+1)^5 - r^5 -> root_data_o=r and rem_data_o=delta. Checked against the reference model for at least 10k operands at full rate.

Source files
------------

// File: rtl/root5_pkg.sv
// Shared types and helpers for the pipelined integer fifth-root extractor.
// The stage struct width follows ROOT_DW; the top's DATA_WIDTH must match it.
package root5_pkg;

    localparam int ROOT_DW = 8;
    localparam int ROOT_XW = 5 * ROOT_DW;

    typedef struct packed {
        logic               valid;
        logic [ROOT_XW-1:0] x;
        logic [ROOT_DW-1:0] r;
    } stage_t;

    function automatic int root5_latency(input int dw);
        return dw + 2;
    endfunction

    // v^5 as a chain of multiplies, each product only as wide as it can get.
    function automatic logic [ROOT_XW-1:0] pow5(input logic [ROOT_DW-1:0] v);
        logic [2*ROOT_DW-1:0] p2;
        logic [3*ROOT_DW-1:0] p3;
        logic [4*ROOT_DW-1:0] p4;
        logic [5*ROOT_DW-1:0] p5;
        p2 = (2*ROOT_DW)'(v) * (2*ROOT_DW)'(v);
        p3 = (3*ROOT_DW)'(p2) * (3*ROOT_DW)'(v);
        p4 = (4*ROOT_DW)'(p3) * (4*ROOT_DW)'(v);
        p5 = (5*ROOT_DW)'(p4) * (5*ROOT_DW)'(v);
        return p5;
    endfunction

endpackage

// File: rtl/root5_trial_stage.sv
// One trial stage: tries setting root bit BIT and keeps it if the
// candidate's fifth power does not exceed the operand.
module root5_trial_stage
    import root5_pkg::*;
#(
    parameter int DATA_WIDTH = ROOT_DW,
    parameter int BIT        = 0
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  stage_t stage_i,
    output stage_t stage_o
);

    localparam logic [DATA_WIDTH-1:0] BIT_MASK = DATA_WIDTH'(1) << BIT;

    logic [DATA_WIDTH-1:0] cand;
    logic [ROOT_XW-1:0]    cand_pow;
    logic                  take;
    stage_t                stage_q;
    stage_t                stage_d;

    always_comb begin
        cand     = stage_i.r | BIT_MASK;
        cand_pow = pow5(cand);
        take     = (cand_pow <= stage_i.x);
        stage_d  = stage_q;
        stage_d.valid = stage_i.valid;
        if (stage_i.valid) begin
            stage_d.x = stage_i.x;
            stage_d.r = take ? cand : stage_i.r;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/root5_pipelined.sv
// Pipelined floor fifth root: input register, one trial stage per root bit
// (MSB first), then an output register producing root, remainder and exact.
module root5_pipelined
    import root5_pkg::*;
#(
    parameter int DATA_WIDTH = ROOT_DW
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [5*DATA_WIDTH-1:0] root_data_i,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   root_data_o,
    output logic [5*DATA_WIDTH-1:0] rem_data_o,
    output logic                    exact_o
);

    localparam int LATENCY    = root5_latency(DATA_WIDTH);
    localparam int NUM_TRIALS = LATENCY - 2;

    stage_t in_q;
    stage_t pipe [0:NUM_TRIALS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_q <= '0;
        end else begin
            in_q.valid <= valid_i;
            if (valid_i) begin
                in_q.x <= root_data_i;
                in_q.r <= '0;
            end
        end
    end

    assign pipe[0] = in_q;

    for (genvar k = 1; k <= NUM_TRIALS; k++) begin : g_trial
        root5_trial_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .BIT        (DATA_WIDTH - k)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .stage_i (pipe[k-1]),
            .stage_o (pipe[k])
        );
    end

    // The trial method guarantees r^5 <= x, so this subtraction never wraps.
    logic [5*DATA_WIDTH-1:0] rem_d;
    logic                    exact_d;

    always_comb begin
        rem_d   = pipe[NUM_TRIALS].x - pow5(pipe[NUM_TRIALS].r);
        exact_d = (rem_d == '0);
    end

    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   root_q;
    logic [5*DATA_WIDTH-1:0] rem_q;
    logic                    exact_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            root_q  <= '0;
            rem_q   <= '0;
            exact_q <= 1'b0;
        end else begin
            valid_q <= pipe[NUM_TRIALS].valid;
            if (pipe[NUM_TRIALS].valid) begin
                root_q  <= pipe[NUM_TRIALS].r;
                rem_q   <= rem_d;
                exact_q <= exact_d;
            end
        end
    end

    assign valid_o     = valid_q;
    assign root_data_o = root_q;
    assign rem_data_o  = rem_q;
    assign exact_o     = exact_q;

endmodule

// File: tb/tb_root5_pipelined.sv
// Directed and randomized checks of root5_pipelined: results are predicted
// at drive time and matched in order against valid_o, including latency.
module tb_root5_pipelined;

    localparam int DW      = 8;
    localparam int XW      = 5 * DW;
    localparam int LAT     = DW + 2;
    localparam int EXP_W   = DW + XW + 1;
    localparam int N_RAND  = 10000;

    logic          clk_i;
    logic          rst_i;
    logic          valid_i;
    logic [XW-1:0] root_data_i;
    logic          valid_o;
    logic [DW-1:0] root_data_o;
    logic [XW-1:0] rem_data_o;
    logic          exact_o;

    root5_pipelined #(.DATA_WIDTH(DW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .root_data_i (root_data_i),
        .valid_o     (valid_o),
        .root_data_o (root_data_o),
        .rem_data_o  (rem_data_o),
        .exact_o     (exact_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // scoreboard
    logic [EXP_W-1:0] exp_q[$];
    int               exp_cyc_q[$];
    logic [EXP_W-1:0] last_exp = '0;
    int checks = 0;
    int errors = 0;

    function automatic longint unsigned p5(input longint unsigned r);
        return r * r * r * r * r;
    endfunction

    task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_valid: observed valid_o=1 expected 0 at cycle %0d", cyc);
                end else begin
                    logic [EXP_W-1:0] e;
                    int ec;
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    last_exp = e;
                    check_val("root", root_data_o, e[EXP_W-1 -: DW]);
                    check_val("rem", rem_data_o, e[XW:1]);
                    check_val("exact", exact_o, e[0]);
                    check_val("latency", cyc - ec, LAT);
                end
            end else begin
                check_val("hold_root", root_data_o, last_exp[EXP_W-1 -: DW]);
                check_val("hold_rem", rem_data_o, last_exp[XW:1]);
                check_val("hold_exact", exact_o, last_exp[0]);
            end
        end
    end

    // drivers
    task automatic send(input logic [XW-1:0] x, input logic [DW-1:0] r, input logic [XW-1:0] rem);
        valid_i     = 1'b1;
        root_data_i = x;
        exp_q.push_back({r, rem, (rem == '0)});
        exp_cyc_q.push_back(cyc);
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_i     = 1'b0;
            root_data_i = {$urandom, $urandom};
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 4 * LAT) begin
            idle(1);
            budget++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
        end
        idle(2);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_valid"}, valid_o, 0);
        check_val({tag, "_root"}, root_data_o, 0);
        check_val({tag, "_rem"}, rem_data_o, 0);
        check_val({tag, "_exact"}, exact_o, 0);
    endtask

    // stimulus
    initial begin
        rst_i       = 1'b1;
        valid_i     = 1'b0;
        root_data_i = '0;
        repeat (3) @(posedge clk_i);
        #2;
        check_zero_outputs("reset");
        rst_i = 1'b0;
        idle(2);

        // single operands with gaps
        send(40'd0,   8'd0, 40'd0);   idle(12);
        send(40'd31,  8'd1, 40'd30);  idle(12);
        send(40'd243, 8'd3, 40'd0);   idle(12);
        send(40'd244, 8'd3, 40'd1);   idle(12);

        // extremes
        send(40'd1078203909375, 8'd255, 40'd0);
        idle(3);
        send(40'd1099511627775, 8'd255, 40'd21307718400);
        drain();

        // back-to-back, then bubble pattern 1,0,1
        send(40'd32,   8'd2, 40'd0);
        send(40'd1024, 8'd4, 40'd0);
        send(40'd3125, 8'd5, 40'd0);
        send(40'd7776, 8'd6, 40'd0);
        send(40'd7777, 8'd6, 40'd1);
        idle(1);
        send(40'd242,  8'd2, 40'd210);
        drain();

        // reset with five operands in flight
        send(40'd100, 8'd2, 40'd68);
        send(40'd200, 8'd2, 40'd168);
        send(40'd300, 8'd3, 40'd57);
        send(40'd400, 8'd3, 40'd157);
        send(40'd500, 8'd3, 40'd257);
        valid_i = 1'b0;
        idle(2);
        rst_i = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        last_exp = '0;
        #1;
        check_zero_outputs("async_reset");
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        idle(3);
        send(40'd243, 8'd3, 40'd0);
        drain();

        // randomized round trip at full rate
        for (int i = 0; i < N_RAND; i++) begin
            longint unsigned r, base, span, delta;
            r     = longint'($urandom_range(0, 255));
            base  = p5(r);
            span  = p5(r + 1) - base;
            delta = {$urandom, $urandom} % span;
            send(XW'(base + delta), DW'(r), XW'(delta));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule
